mxu_skew_feeder: RTL and testbench
==================================

// Module: mxu_skew_feeder
// PURPOSE
//  Upstream stage of the mxu systolic array. On start, reads a GRIDxGRID operand A and a GRIDxGRID
//  operand B from data memory, then streams them diagonally skewed into mxu west_input/north_input
//  while driving ce. Replaces hand-sequenced per-element buffer loads in the accelerator controller.
// PARAMETERS
//  NUM_SIZE     16  element width in bits (matches mxu lane width)
//  GRID_SIZE    2   systolic array dimension G; operands are GxG, row-major in memory
//  ADDRESS_LEN  5   data-memory address width; address arithmetic wraps modulo 2**ADDRESS_LEN
// PORTS
//  clk          in   1                 rising-edge clock
//  rst          in   1                 asynchronous, active-high reset
//  start        in   1                 1-cycle request; sampled only in IDLE
//  a_base       in   ADDRESS_LEN       base address of A (west operand), latched on accepted start
//  b_base       in   ADDRESS_LEN       base address of B (north operand), latched on accepted start
//  mem_rd_en    out  1                 memory read strobe
//  mem_rd_addr  out  ADDRESS_LEN       memory read address
//  mem_rd_data  in   NUM_SIZE          read data, valid exactly 1 cycle after mem_rd_en
//  west_input   out  NUM_SIZE*G        lane i at [(i+1)*NUM_SIZE-1 : i*NUM_SIZE], row i of A
//  north_input  out  NUM_SIZE*G        lane j at same slicing, column j of B
//  ce           out  1                 mxu clock enable
//  busy         out  1                 high from cycle after accepted start until last STREAM cycle
//  done         out  1                 1-cycle pulse after final STREAM cycle
// BEHAVIOUR
//  - Reset: state=IDLE; mem_rd_en, ce, busy, done = 0; west/north_input = 0; lane storage cleared.
//  - All outputs registered. States: IDLE -> LOAD -> CAPTURE -> STREAM -> DONE -> IDLE.
//  - IDLE: start=1 latches a_base/b_base, goes LOAD. start while not IDLE is ignored (no queueing).
//  - LOAD: 2*G*G cycles, mem_rd_en=1. Read k (0..G*G-1) addr=a_base+k; then k'=0..G*G-1 addr=b_base+k'.
//    Data returned for A[r][c] -> west lane r slot c; B[r][c] -> north lane c slot r.
//  - CAPTURE: 1 cycle, mem_rd_en=0, stores the last returned element.
//  - STREAM: 3G-2 cycles, ce=1, t=0..3G-3. Lane i outputs slot (t-i) if 0<=t-i<G else 0.
//    Trailing zero cycles flush the array so every PE has accumulated its final product.
//  - DONE: done=1, busy=0, ce=0, lane outputs 0; next cycle IDLE (start accepted again from there).
//  - Outside STREAM west_input/north_input are 0 and ce=0.
//  - Latency for G=2: start@0 -> reads @1..8 -> CAPTURE @9 -> STREAM @10..13 -> done @14.
//  - No arithmetic beyond address add; address overflow wraps (base 30, k=3 -> addr 1).
//  - rst asserted mid-operation: immediate return to IDLE, all outputs 0, partial loads discarded;
//    mxu sees ce=0 and is expected to be reset alongside.
//  - start asserted in same cycle as done: ignored (state is DONE, not IDLE).
// STRUCTURE
//  - Shared package mxu_pkg: NUM_SIZE, GRID_SIZE, feeder state enum (IDLE/LOAD/CAPTURE/STREAM/DONE).
//  - Sub-module skew_lane (instantiated 2*G times): G-slot element store with write port
//    (slot, data, we) and a read mux indexed by (t - lane_id), emitting 0 outside [0,G).
//  - Top holds FSM, read-address counter, stream counter t, and lane write-select decode.
// TESTING
//  1. Reset: rst mid-LOAD (cycle 5) -> next edge all outputs 0, state IDLE; fresh start runs full.
//  2. G=2, A=[[1,2],[3,4]] @0, B=[[5,6],[7,8]] @4 -> STREAM west0=1,2,0,0; west1=0,3,4,0;
//     north0=5,7,0,0; north1=0,6,8,0; ce=1 cycles 10..13; done cycle 14.
//  3. Read trace: same test -> mem_rd_addr 0,1,2,3,4,5,6,7 on cycles 1..8, mem_rd_en=0 at cycle 9.
//  4. Wrap: a_base=30 -> addresses 30,31,0,1; data mapped as A row-major, stream values match.
//  5. start held high through busy and on done cycle -> exactly one run; restart only from IDLE.
//  6. End-to-end with mxu: result = [[19,22],[43,50]] after done; back-to-back runs give same result
//     when mxu is cleared between runs.

Source files
------------

// File: rtl/mxu_pkg.sv
// Shared constants and state encoding for the mxu operand skew feeder.
// Lane width, array dimension and memory address width live here.
package mxu_pkg;

    localparam int NUM_SIZE    = 16;
    localparam int GRID_SIZE   = 2;
    localparam int ADDRESS_LEN = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        STREAM,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/mxu_skew_feeder_if.sv
// Bundle between the accelerator controller / data memory and the feeder.
// master = controller + memory side, slave = feeder.
interface mxu_skew_feeder_if #(
    parameter int NUM_SIZE    = mxu_pkg::NUM_SIZE,
    parameter int GRID_SIZE   = mxu_pkg::GRID_SIZE,
    parameter int ADDRESS_LEN = mxu_pkg::ADDRESS_LEN
);

    logic                          start;
    logic [ADDRESS_LEN-1:0]        a_base;
    logic [ADDRESS_LEN-1:0]        b_base;
    logic                          mem_rd_en;
    logic [ADDRESS_LEN-1:0]        mem_rd_addr;
    logic [NUM_SIZE-1:0]           mem_rd_data;
    logic [NUM_SIZE*GRID_SIZE-1:0] west_input;
    logic [NUM_SIZE*GRID_SIZE-1:0] north_input;
    logic                          ce;
    logic                          busy;
    logic                          done;

    modport master (
        output start, a_base, b_base, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, west_input, north_input,
        input  ce, busy, done
    );

    modport slave (
        input  start, a_base, b_base, mem_rd_data,
        output mem_rd_en, mem_rd_addr, west_input, north_input,
        output ce, busy, done
    );

endinterface

// File: rtl/mxu_skew_feeder_lane.sv
// One skew lane: G-slot element store, read back by stream step t
// delayed by the lane index, zero outside the lane's window.
module skew_lane #(
    parameter int NUM_SIZE  = 16,
    parameter int GRID_SIZE = 2,
    parameter int CNT_W     = 4,
    parameter int LANE_ID   = 0,
    localparam int SLOT_W   = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [SLOT_W-1:0]   slot,
    input  logic [NUM_SIZE-1:0] wdata,
    input  logic [CNT_W-1:0]    t,
    output logic [NUM_SIZE-1:0] rdata
);

    logic [NUM_SIZE-1:0] slots [GRID_SIZE];

    // element store, cleared on reset so stale operands never leak
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < GRID_SIZE; s++) begin
                slots[s] <= '0;
            end
        end else if (we) begin
            slots[slot] <= wdata;
        end
    end

    // skewed read: slot (t - lane) inside [0,G), zero otherwise
    always_comb begin
        rdata = '0;
        for (int s = 0; s < GRID_SIZE; s++) begin
            if (int'(t) - LANE_ID == s) begin
                rdata = slots[s];
            end
        end
    end

endmodule

// File: rtl/mxu_skew_feeder.sv
// Loads GxG operands A and B from data memory, then streams them
// diagonally skewed into the mxu west/north edges with ce asserted.
module mxu_skew_feeder #(
    parameter int NUM_SIZE    = mxu_pkg::NUM_SIZE,
    parameter int GRID_SIZE   = mxu_pkg::GRID_SIZE,
    parameter int ADDRESS_LEN = mxu_pkg::ADDRESS_LEN
) (
    input logic              clk,
    input logic              rst,
    mxu_skew_feeder_if.slave bus
);

    import mxu_pkg::*;

    localparam int G          = GRID_SIZE;
    localparam int NSQ        = G * G;
    localparam int LOAD_LEN   = 2 * NSQ;
    localparam int STREAM_LEN = 3 * G - 2;
    localparam int CNT_W      = $clog2(LOAD_LEN + STREAM_LEN + 1);
    localparam int SLOT_W     = (G > 1) ? $clog2(G) : 1;

    feeder_state_t state, state_n;

    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [ADDRESS_LEN-1:0] a_base_q, b_base_q;
    logic [ADDRESS_LEN-1:0] a_eff, b_eff;
    logic                   rd_q;
    logic [CNT_W-1:0]       idx_q;

    logic                      rd_en_d, ce_d, busy_d, done_d;
    logic [ADDRESS_LEN-1:0]    addr_d;
    logic [G-1:0][NUM_SIZE-1:0] west_rd, north_rd;
    logic [G-1:0]               west_we, north_we;
    logic [G-1:0][SLOT_W-1:0]   west_slot, north_slot;

    // first read address must use the live base, later ones the latched copy
    assign a_eff = (state == IDLE) ? bus.a_base : a_base_q;
    assign b_eff = (state == IDLE) ? bus.b_base : b_base_q;

    // state, phase counter and latched operand bases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && bus.start) begin
                a_base_q <= bus.a_base;
                b_base_q <= bus.b_base;
            end
        end
    end

    // phase sequencing; start only honoured from IDLE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                if (cnt == CNT_W'(LOAD_LEN - 1)) begin
                    state_n = CAPTURE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            CAPTURE: begin
                state_n = STREAM;
                cnt_n   = '0;
            end
            STREAM: begin
                if (cnt == CNT_W'(STREAM_LEN - 1)) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // next-cycle output values, derived from the state being entered
    always_comb begin
        rd_en_d = 1'b0;
        addr_d  = '0;
        ce_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_n)
            LOAD: begin
                rd_en_d = 1'b1;
                busy_d  = 1'b1;
                if (cnt_n < CNT_W'(NSQ)) begin
                    addr_d = a_eff + ADDRESS_LEN'(cnt_n);
                end else begin
                    addr_d = b_eff + ADDRESS_LEN'(cnt_n - CNT_W'(NSQ));
                end
            end
            CAPTURE: begin
                busy_d = 1'b1;
            end
            STREAM: begin
                ce_d   = 1'b1;
                busy_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // registered outputs; lanes only drive the mxu while streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.ce          <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.west_input  <= '0;
            bus.north_input <= '0;
        end else begin
            bus.mem_rd_en   <= rd_en_d;
            bus.mem_rd_addr <= addr_d;
            bus.ce          <= ce_d;
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            bus.west_input  <= ce_d ? west_rd : '0;
            bus.north_input <= ce_d ? north_rd : '0;
        end
    end

    // remember which read is in flight so its data lands in the right slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= 1'b0;
            idx_q <= '0;
        end else begin
            rd_q  <= bus.mem_rd_en;
            idx_q <= cnt;
        end
    end

    // A[r][c] -> west lane r slot c, B[r][c] -> north lane c slot r
    always_comb begin
        west_we    = '0;
        north_we   = '0;
        west_slot  = '0;
        north_slot = '0;
        for (int r = 0; r < G; r++) begin
            for (int c = 0; c < G; c++) begin
                if (rd_q && idx_q == CNT_W'(r * G + c)) begin
                    west_we[r]   = 1'b1;
                    west_slot[r] = SLOT_W'(c);
                end
                if (rd_q && idx_q == CNT_W'(NSQ + r * G + c)) begin
                    north_we[c]   = 1'b1;
                    north_slot[c] = SLOT_W'(r);
                end
            end
        end
    end

    for (genvar i = 0; i < G; i++) begin : g_lane
        skew_lane #(
            .NUM_SIZE  (NUM_SIZE),
            .GRID_SIZE (G),
            .CNT_W     (CNT_W),
            .LANE_ID   (i)
        ) u_west (
            .clk   (clk),
            .rst   (rst),
            .we    (west_we[i]),
            .slot  (west_slot[i]),
            .wdata (bus.mem_rd_data),
            .t     (cnt_n),
            .rdata (west_rd[i])
        );

        skew_lane #(
            .NUM_SIZE  (NUM_SIZE),
            .GRID_SIZE (G),
            .CNT_W     (CNT_W),
            .LANE_ID   (i)
        ) u_north (
            .clk   (clk),
            .rst   (rst),
            .we    (north_we[i]),
            .slot  (north_slot[i]),
            .wdata (bus.mem_rd_data),
            .t     (cnt_n),
            .rdata (north_rd[i])
        );
    end

endmodule

// File: tb/tb_mxu_skew_feeder.sv
// Self-checking bench for mxu_skew_feeder: memory model, output-stationary
// mxu model, per-cycle expected trace and end-to-end product check.
module tb_mxu_skew_feeder;

    import mxu_pkg::*;

    localparam int G        = GRID_SIZE;
    localparam int N        = NUM_SIZE;
    localparam int AW       = ADDRESS_LEN;
    localparam int NSQ      = G * G;
    localparam int LOAD_LEN = 2 * NSQ;
    localparam int DONE_CYC = LOAD_LEN + 3 * G;

    typedef logic [NSQ-1:0][N-1:0]  mat_t;
    typedef logic [NSQ-1:0][31:0]   res_t;

    typedef struct {
        logic [AW-1:0] a_base;
        logic [AW-1:0] b_base;
        mat_t          a;
        mat_t          b;
        res_t          c;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic mxu_clr;
    int   n_checks = 0;
    int   n_fail   = 0;

    mxu_skew_feeder_if bus ();

    mxu_skew_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // data memory: 1-cycle read latency, garbage when not reading
    logic [N-1:0] mem [2**AW];
    always @(posedge clk) begin
        bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_rd_addr] : N'($urandom);
    end

    // output-stationary systolic array fed from the west/north edges
    logic [31:0]  acc  [G][G];
    logic [N-1:0] hreg [G][G];
    logic [N-1:0] vreg [G][G];
    always @(posedge clk) begin
        for (int i = 0; i < G; i++) begin
            for (int j = 0; j < G; j++) begin
                logic [N-1:0] a_in;
                logic [N-1:0] b_in;
                if (j == 0) a_in = bus.west_input[i*N +: N];
                else        a_in = hreg[i][j-1];
                if (i == 0) b_in = bus.north_input[j*N +: N];
                else        b_in = vreg[i-1][j];
                if (mxu_clr) begin
                    acc[i][j]  <= '0;
                    hreg[i][j] <= '0;
                    vreg[i][j] <= '0;
                end else if (bus.ce) begin
                    acc[i][j]  <= acc[i][j] + 32'(a_in) * 32'(b_in);
                    hreg[i][j] <= a_in;
                    vreg[i][j] <= b_in;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mat_t m4(input int e0, e1, e2, e3);
        mat_t m;
        m[0] = N'(e0);
        m[1] = N'(e1);
        m[2] = N'(e2);
        m[3] = N'(e3);
        return m;
    endfunction

    function automatic res_t r4(input int e0, e1, e2, e3);
        res_t r;
        r[0] = e0;
        r[1] = e1;
        r[2] = e2;
        r[3] = e3;
        return r;
    endfunction

    function automatic res_t matmul(input mat_t a, input mat_t b);
        res_t r;
        for (int i = 0; i < G; i++) begin
            for (int j = 0; j < G; j++) begin
                int s = 0;
                for (int k = 0; k < G; k++) begin
                    s += int'(a[i*G+k]) * int'(b[k*G+j]);
                end
                r[i*G+j] = s;
            end
        end
        return r;
    endfunction

    // one full operation, every cycle compared against the timing rules
    task automatic run_op(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                          input mat_t a, input mat_t b, input bit hold,
                          output res_t c_out);
        for (int k = 0; k < NSQ; k++) begin
            mem[AW'(int'(ab) + k)] = a[k];
            mem[AW'(int'(bb) + k)] = b[k];
        end
        mxu_clr = 1'b1;
        @(negedge clk);
        mxu_clr    = 1'b0;
        bus.start  = 1'b1;
        bus.a_base = ab;
        bus.b_base = bb;
        for (int c = 1; c <= DONE_CYC + 2; c++) begin
            logic [G-1:0][N-1:0] ew;
            logic [G-1:0][N-1:0] en;
            logic [AW-1:0] ea;
            bit e_rd, e_ce, e_busy, e_done;
            int t;
            @(negedge clk);
            if (!hold || c == DONE_CYC + 1) bus.start = 1'b0;
            bus.a_base = AW'($urandom);
            bus.b_base = AW'($urandom);
            e_rd   = (c >= 1) && (c <= LOAD_LEN);
            e_ce   = (c >= LOAD_LEN + 2) && (c <= DONE_CYC - 1);
            e_busy = (c >= 1) && (c <= DONE_CYC - 1);
            e_done = (c == DONE_CYC);
            t      = c - LOAD_LEN - 2;
            ew = '0;
            en = '0;
            if (e_ce) begin
                for (int i = 0; i < G; i++) begin
                    int s = t - i;
                    if (s >= 0 && s < G) begin
                        ew[i] = a[i*G+s];
                        en[i] = b[s*G+i];
                    end
                end
            end
            check($sformatf("c%0d mem_rd_en", c), 64'(bus.mem_rd_en), 64'(e_rd));
            check($sformatf("c%0d ce", c), 64'(bus.ce), 64'(e_ce));
            check($sformatf("c%0d busy", c), 64'(bus.busy), 64'(e_busy));
            check($sformatf("c%0d done", c), 64'(bus.done), 64'(e_done));
            check($sformatf("c%0d west", c), 64'(bus.west_input), 64'(ew));
            check($sformatf("c%0d north", c), 64'(bus.north_input), 64'(en));
            if (e_rd) begin
                int k = c - 1;
                ea = (k < NSQ) ? AW'(int'(ab) + k) : AW'(int'(bb) + k - NSQ);
                check($sformatf("c%0d mem_rd_addr", c), 64'(bus.mem_rd_addr), 64'(ea));
            end
        end
        for (int i = 0; i < G; i++) begin
            for (int j = 0; j < G; j++) begin
                c_out[i*G+j] = acc[i][j];
            end
        end
    endtask

    vec_t tbl [3];
    res_t got;
    res_t first;

    initial begin
        tbl[0] = '{a_base: 5'd0,  b_base: 5'd4,  a: m4(1, 2, 3, 4),
                   b: m4(5, 6, 7, 8), c: r4(19, 22, 43, 50)};
        tbl[1] = '{a_base: 5'd30, b_base: 5'd10, a: m4(2, 0, 0, 2),
                   b: m4(1, 2, 3, 4), c: r4(2, 4, 6, 8)};
        tbl[2] = '{a_base: 5'd12, b_base: 5'd28, a: m4(1, 1, 1, 1),
                   b: m4(1, 2, 3, 4), c: r4(4, 6, 4, 6)};

        for (int i = 0; i < 2**AW; i++) mem[i] = N'($urandom);
        rst        = 1'b1;
        mxu_clr    = 1'b0;
        bus.start  = 1'b0;
        bus.a_base = '0;
        bus.b_base = '0;
        repeat (2) @(negedge clk);
        check("reset ctrl", 64'({bus.mem_rd_en, bus.ce, bus.busy, bus.done}), 64'(0));
        check("reset lanes", 64'({bus.west_input, bus.north_input}), 64'(0));
        rst = 1'b0;

        // reset asserted in the middle of LOAD
        bus.start  = 1'b1;
        bus.a_base = 5'd0;
        bus.b_base = 5'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("midload rd_en", 64'(bus.mem_rd_en), 64'(1));
        rst = 1'b1;
        #1;
        check("midload rst ctrl", 64'({bus.mem_rd_en, bus.ce, bus.busy, bus.done}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post rst idle", 64'({bus.mem_rd_en, bus.ce, bus.busy, bus.done}), 64'(0));
        check("post rst lanes", 64'({bus.west_input, bus.north_input}), 64'(0));

        // directed vectors
        for (int v = 0; v < 3; v++) begin
            run_op(tbl[v].a_base, tbl[v].b_base, tbl[v].a, tbl[v].b, 1'b0, got);
            for (int k = 0; k < NSQ; k++) begin
                check($sformatf("vec%0d C[%0d]", v, k), 64'(got[k]), 64'(tbl[v].c[k]));
            end
        end

        // start held through busy and the done cycle, then back-to-back
        run_op(tbl[0].a_base, tbl[0].b_base, tbl[0].a, tbl[0].b, 1'b1, first);
        run_op(tbl[0].a_base, tbl[0].b_base, tbl[0].a, tbl[0].b, 1'b0, got);
        for (int k = 0; k < NSQ; k++) begin
            check($sformatf("held C[%0d]", k), 64'(first[k]), 64'(tbl[0].c[k]));
            check($sformatf("b2b C[%0d]", k), 64'(got[k]), 64'(tbl[0].c[k]));
        end

        // randomized operands and bases against a plain matrix product
        for (int r = 0; r < 6; r++) begin
            mat_t ra, rb;
            logic [AW-1:0] ab, bb;
            for (int k = 0; k < NSQ; k++) begin
                ra[k] = N'($urandom_range(0, 255));
                rb[k] = N'($urandom_range(0, 255));
            end
            ab = AW'($urandom_range(0, 2**AW - 1));
            bb = AW'(int'(ab) + NSQ + int'($urandom_range(0, 2**AW - 2 * NSQ)));
            run_op(ab, bb, ra, rb, 1'b0, got);
            for (int k = 0; k < NSQ; k++) begin
                check($sformatf("rnd%0d C[%0d]", r, k), 64'(got[k]), 64'(matmul(ra, rb)[k]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
